// File: rtl/param_seq_alu.sv
// Purpose : registered WIDTH-bit ALU (add/sub/carry-chain, logic, shifts, shift-add MUL, MOV) with NZCV flag register.
// Latency : 1 cycle for single-cycle ops, 1+k for shifts by k, 1+WIDTH for MUL; one op in flight.
// Backpr. : accepts only in IDLE (in_ready); result/out_err/flags held in DONE until out_ready.
// Ports   : clk/rst (sync, active-high); in_valid/in_ready + op, set_flags, A, B request side;
//           out_valid/out_ready + result, out_err response side; flag_N/Z/C/V flag register.
module param_seq_alu #(
    parameter int WIDTH = 16,
    localparam int SW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_err,
    output logic             flag_N,
    output logic             flag_Z,
    output logic             flag_C,
    output logic             flag_V
);
    // Counter must reach WIDTH for MUL, so one bit wider than the shift amount.
    localparam int CW = SW + 1;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_ADC = 4'd2,  OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_SRA = 4'd10, OP_MUL = 4'd11;
    localparam logic [3:0] OP_MOV = 4'd12;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             sf_q, sf_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d;     // latched flag_C; doubles as shift carry-out
    logic [WIDTH-1:0] acc_q, acc_d;     // shift work register / MUL low half (multiplier)
    logic [WIDTH-1:0] hi_q, hi_d;       // MUL high half
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic             fn_q, fn_d, fz_q, fz_d, fc_q, fc_d, fv_q, fv_d;

    logic [WIDTH-1:0] b_eff, res;
    logic             arith_cin, c_new, v_new, wr_flags, is_shift;
    logic [WIDTH:0]   sum, madd;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign out_err   = err_q;
    assign flag_N    = fn_q;
    assign flag_Z    = fz_q;
    assign flag_C    = fc_q;
    assign flag_V    = fv_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sf_d     = sf_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        fn_d     = fn_q;
        fz_d     = fz_q;
        fc_d     = fc_q;
        fv_d     = fv_q;
        res      = '0;
        c_new    = fc_q;
        v_new    = fv_q;
        wr_flags = sf_q;

        // SUB/SBC add the complement; carry-in is 0, 1 or the latched C.
        b_eff     = (op_q == OP_SUB || op_q == OP_SBC) ? ~b_q : b_q;
        arith_cin = (op_q == OP_ADD) ? 1'b0 : (op_q == OP_SUB) ? 1'b1 : cin_q;
        sum       = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, arith_cin};
        // One shift-add step: conditionally add multiplicand into the high half.
        madd      = {1'b0, hi_q} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        is_shift  = (op_q == OP_SHL) || (op_q == OP_SHR) || (op_q == OP_SRA);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    sf_d    = set_flags;
                    a_d     = A;
                    b_d     = B;
                    cin_d   = fc_q;
                    acc_d   = (op == OP_MUL) ? B : A;
                    hi_d    = '0;
                    cnt_d   = (op == OP_MUL) ? CW'(WIDTH) : {1'b0, B[SW-1:0]};
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_shift && cnt_q != '0) begin
                    case (op_q)
                        OP_SHL:  begin cin_d = acc_q[WIDTH-1]; acc_d = {acc_q[WIDTH-2:0], 1'b0}; end
                        OP_SHR:  begin cin_d = acc_q[0]; acc_d = {1'b0, acc_q[WIDTH-1:1]}; end
                        default: begin cin_d = acc_q[0]; acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]}; end
                    endcase
                    cnt_d = cnt_q - CW'(1);
                end else if (op_q == OP_MUL && cnt_q != '0) begin
                    {hi_d, acc_d} = {madd, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    case (op_q)
                        OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                            res   = sum[WIDTH-1:0];
                            c_new = sum[WIDTH];
                            v_new = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
                        end
                        OP_AND: begin res = a_q & b_q; v_new = 1'b0; end
                        OP_OR:  begin res = a_q | b_q; v_new = 1'b0; end
                        OP_XOR: begin res = a_q ^ b_q; v_new = 1'b0; end
                        OP_NOT: begin res = ~a_q;      v_new = 1'b0; end
                        // cin_q still holds the entry C when the shift amount was 0.
                        OP_SHL, OP_SHR, OP_SRA: begin res = acc_q; c_new = cin_q; v_new = 1'b0; end
                        OP_MUL: begin res = acc_q; c_new = |hi_q; v_new = 1'b0; end
                        OP_MOV: res = b_q;
                        default: wr_flags = 1'b0;
                    endcase
                    result_d = res;
                    err_d    = (op_q > OP_MOV);
                    if (wr_flags) begin
                        fn_d = res[WIDTH-1];
                        fz_d = (res == '0);
                        fc_d = c_new;
                        fv_d = v_new;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sf_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            acc_q    <= '0;
            hi_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            fn_q     <= 1'b0;
            fz_q     <= 1'b0;
            fc_q     <= 1'b0;
            fv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sf_q     <= sf_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
            fn_q     <= fn_d;
            fz_q     <= fz_d;
            fc_q     <= fc_d;
            fv_q     <= fv_d;
        end
    end
endmodule

// File: tb/tb_param_seq_alu.sv
// Bench for param_seq_alu (WIDTH=16): directed scenarios plus randomized ops against a reference model.
// Inputs driven on negedge or 1 time unit after posedge; outputs sampled 1 time unit after posedge.
// Model tracks the NZCV register so carry-chained ops can be predicted across operations.
module tb_param_seq_alu;
    localparam int W = 16;

    logic          clk, rst, in_valid, in_ready, set_flags, out_valid, out_ready, out_err;
    logic [3:0]    op;
    logic [W-1:0]  A, B, result;
    logic          flag_N, flag_Z, flag_C, flag_V;

    int vec = 0;
    int fails = 0;
    logic m_n = 0, m_z = 0, m_c = 0, m_v = 0;

    param_seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .set_flags(set_flags), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_err(out_err), .flag_N(flag_N), .flag_Z(flag_Z),
        .flag_C(flag_C), .flag_V(flag_V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the opcode rules; updates model flags.
    task automatic model_op(input logic [3:0] mop, input logic [15:0] a, input logic [15:0] b,
                            input logic sf, output logic [15:0] r, output logic e, output int lat);
        int k, sa, sb, t;
        longint s;
        logic [15:0] be;
        logic [31:0] p;
        logic c, v, cin;
        c = m_c; v = m_v; e = 1'b0; lat = 1; k = int'(b[3:0]); r = '0;
        case (mop)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                be  = (mop == 4'd1 || mop == 4'd3) ? ~b : b;
                cin = (mop == 4'd0) ? 1'b0 : (mop == 4'd1) ? 1'b1 : m_c;
                s   = longint'(a) + longint'(be) + longint'(cin);
                r   = s[15:0];
                c   = (s >= 65536);
                sa  = int'($signed(a));
                sb  = int'($signed(be));
                t   = sa + sb + int'(cin);
                v   = (t > 32767) || (t < -32768);
            end
            4'd4: begin r = a & b; v = 1'b0; end
            4'd5: begin r = a | b; v = 1'b0; end
            4'd6: begin r = a ^ b; v = 1'b0; end
            4'd7: begin r = ~a;    v = 1'b0; end
            4'd8: begin r = a << k; if (k != 0) c = a[16-k]; v = 1'b0; lat = 1 + k; end
            4'd9: begin r = a >> k; if (k != 0) c = a[k-1]; v = 1'b0; lat = 1 + k; end
            4'd10: begin
                sa = int'($signed(a));
                r  = 16'(sa >>> k);
                if (k != 0) c = a[k-1];
                v = 1'b0; lat = 1 + k;
            end
            4'd11: begin p = a * b; r = p[15:0]; c = (p[31:16] != 0); v = 1'b0; lat = 17; end
            4'd12: r = b;
            default: e = 1'b1;
        endcase
        if (sf && !e) begin
            m_n = r[15]; m_z = (r == 0); m_c = c; m_v = v;
        end
    endtask

    // Issue one op, measure cycles from accept edge to out_valid, capture outputs, then acknowledge.
    task automatic do_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b, input logic sf,
                         output logic [15:0] r, output logic e, output logic [3:0] f, output int lat);
        @(negedge clk);
        op = o; A = a; B = b; set_flags = sf; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble the request bus: the op in flight must not see it.
        op = 4'($urandom); A = 16'($urandom); B = 16'($urandom); set_flags = ~sf;
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result; e = out_err; f = {flag_N, flag_Z, flag_C, flag_V};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_n = 0; m_z = 0; m_c = 0; m_v = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        vec++;
        if ({in_ready, out_valid, result, out_err, flag_N, flag_Z, flag_C, flag_V} !== {1'b1, 1'b0, 16'h0, 1'b0, 4'b0000}) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h err=%b nzcv=%b%b%b%b need rdy=1 vld=0 res=0000 err=0 nzcv=0000",
                     in_ready, out_valid, result, out_err, flag_N, flag_Z, flag_C, flag_V);
        end
    endtask

    // Directed op: compare {result, err, NZCV, latency} against literal expectations.
    task automatic directed(input string name, input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                            input logic sf, input logic [15:0] xr, input logic xe, input logic [3:0] xf, input int xl);
        logic [15:0] r, mr; logic e, me; logic [3:0] f; int lat, ml;
        do_op(o, a, b, sf, r, e, f, lat);
        model_op(o, a, b, sf, mr, me, ml);
        vec++;
        if ({r, e, f, 8'(lat)} !== {xr, xe, xf, 8'(xl)}) begin
            fails++;
            $display("FAIL %s: got res=%h err=%b nzcv=%b lat=%0d need res=%h err=%b nzcv=%b lat=%0d",
                     name, r, e, f, lat, xr, xe, xf, xl);
        end
    endtask

    task automatic test_add();
        directed("add_ovf",  4'd0, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 4'b1001, 1);
        directed("add_wrap", 4'd0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b0, 4'b0110, 1);
    endtask

    task automatic test_carry_chain();
        directed("sub_zero", 4'd1, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 4'b0110, 1);
        directed("sbc_c1",   4'd3, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 4'b1000, 1);
        directed("adc_c0",   4'd2, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 4'b0000, 1);
    endtask

    task automatic test_shift();
        directed("sra_15",  4'd10, 16'h8000, 16'h000F, 1'b1, 16'hFFFF, 1'b0, 4'b1000, 16);
        directed("shl_1",   4'd8,  16'h8001, 16'h0001, 1'b1, 16'h0002, 1'b0, 4'b0010, 2);
        directed("shr_0",   4'd9,  16'h1234, 16'h0010, 1'b1, 16'h1234, 1'b0, 4'b0010, 1);
    endtask

    task automatic test_mul();
        directed("mul_hi",  4'd11, 16'h0100, 16'h0100, 1'b1, 16'h0000, 1'b0, 4'b0110, 17);
        directed("mul_lo",  4'd11, 16'h00FF, 16'h0003, 1'b1, 16'h02FD, 1'b0, 4'b0000, 17);
    endtask

    task automatic test_backpressure();
        logic [15:0] mr; logic me; int ml;
        @(negedge clk);
        op = 4'd0; A = 16'hFFFF; B = 16'h0001; set_flags = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        model_op(4'd0, 16'hFFFF, 16'h0001, 1'b1, mr, me, ml);
        for (int i = 0; i < 6; i++) begin
            vec++;
            if ({out_valid, in_ready, result, out_err, flag_N, flag_Z, flag_C, flag_V} !== {1'b1, 1'b0, 16'h0000, 1'b0, 4'b0110}) begin
                fails++;
                $display("FAIL hold_%0d: got vld=%b rdy=%b res=%h err=%b nzcv=%b%b%b%b need vld=1 rdy=0 res=0000 err=0 nzcv=0110",
                         i, out_valid, in_ready, result, out_err, flag_N, flag_Z, flag_C, flag_V);
            end
            op = 4'd1; A = 16'h0003; B = 16'h0003;
            in_valid = (i == 1 || i == 3);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL ignored_pulse: got vld=%b rdy=%b need vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        op = 4'd11; A = 16'hFFFF; B = 16'hFFFF; set_flags = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        vec++;
        if ({out_valid, in_ready, result, out_err, flag_N, flag_Z, flag_C, flag_V} !== {1'b0, 1'b1, 16'h0, 1'b0, 4'b0000}) begin
            fails++;
            $display("FAIL rst_mid_mul: got vld=%b rdy=%b res=%h err=%b nzcv=%b%b%b%b need vld=0 rdy=1 res=0000 err=0 nzcv=0000",
                     out_valid, in_ready, result, out_err, flag_N, flag_Z, flag_C, flag_V);
        end
        @(negedge clk);
        rst = 1'b0;
        m_n = 0; m_z = 0; m_c = 0; m_v = 0;
        seen = 0;
        repeat (24) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        vec++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL rst_abort: got %0d cycles of out_valid after reset need 0", seen);
        end
    endtask

    task automatic test_flag_ctrl();
        directed("set_nv",    4'd0,  16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 4'b1001, 1);
        directed("sf0_add",   4'd0,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 4'b1001, 1);
        directed("reserved",  4'd13, 16'h0005, 16'h0006, 1'b1, 16'h0000, 1'b1, 4'b1001, 1);
        directed("reserved15",4'd15, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 4'b1001, 1);
        directed("mov",       4'd12, 16'h1111, 16'h8000, 1'b1, 16'h8000, 1'b0, 4'b1001, 1);
    endtask

    task automatic test_random();
        logic [15:0] a, b, r, xr; logic [3:0] o, f; logic sf, e, xe; int lat, xl;
        for (int n = 0; n < 120; n++) begin
            o  = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = 16'($urandom);
            sf = ($urandom_range(0, 3) != 0);
            do_op(o, a, b, sf, r, e, f, lat);
            model_op(o, a, b, sf, xr, xe, xl);
            vec++;
            if ({r, e, f, 8'(lat)} !== {xr, xe, m_n, m_z, m_c, m_v, 8'(xl)}) begin
                fails++;
                $display("FAIL rand_%0d op=%0d a=%h b=%h sf=%b: got res=%h err=%b nzcv=%b lat=%0d need res=%h err=%b nzcv=%b%b%b%b lat=%0d",
                         n, o, a, b, sf, r, e, f, lat, xr, xe, m_n, m_z, m_c, m_v, xl);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; set_flags = 1'b0; A = '0; B = '0;
        test_reset();
        test_add();
        test_carry_chain();
        test_shift();
        test_mul();
        test_backpressure();
        test_reset_mid();
        test_flag_ctrl();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end
endmodule
